// File: rtl/stopwatch_ctrl_99sec.sv
// 00..99 second stopwatch with pause, lap-freeze display and active-low 7-seg decode.
// Outputs are registered one edge after the accepting edge; pulse inputs, no backpressure.
module stopwatch_ctrl_99sec #(
   parameter int DIV = 50000000
) (
   input  logic       clkIn,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [0:6] digit1,
   output logic [0:6] digit0,
   output logic       indicator,
   output logic       running,
   output logic       done
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state, state_nx;
   logic [PW-1:0] presc, presc_nx;
   logic [3:0]    tens, tens_nx, units, units_nx;
   logic [3:0]    disp_t, disp_t_nx, disp_u, disp_u_nx;
   logic          freeze, freeze_nx;
   logic          ind_nx;
   logic [3:0]    shown_t, shown_u;

   function automatic logic [0:6] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   always_ff @(posedge clkIn) begin
      if (!rst) begin
         state     <= IDLE;
         presc     <= '0;
         tens      <= 4'd0;
         units     <= 4'd0;
         disp_t    <= 4'd0;
         disp_u    <= 4'd0;
         freeze    <= 1'b0;
         indicator <= 1'b0;
         running   <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         presc     <= presc_nx;
         tens      <= tens_nx;
         units     <= units_nx;
         disp_t    <= disp_t_nx;
         disp_u    <= disp_u_nx;
         freeze    <= freeze_nx;
         indicator <= ind_nx;
         running   <= (state_nx == RUN);
         done      <= (state_nx == DONE);
      end
   end

   always_comb begin
      state_nx  = state;
      presc_nx  = presc;
      tens_nx   = tens;
      units_nx  = units;
      disp_t_nx = disp_t;
      disp_u_nx = disp_u;
      freeze_nx = freeze;
      ind_nx    = indicator;
      if (clear) begin
         state_nx  = IDLE;
         presc_nx  = '0;
         tens_nx   = 4'd0;
         units_nx  = 4'd0;
         freeze_nx = 1'b0;
         ind_nx    = 1'b0;
      end else begin
         if (lap && (state == RUN || state == PAUSE)) begin
            if (!freeze) begin
               disp_t_nx = tens;
               disp_u_nx = units;
               freeze_nx = 1'b1;
            end else begin
               freeze_nx = 1'b0;
            end
         end
         case (state)
            IDLE:  if (start_stop) state_nx = RUN;
            PAUSE: if (start_stop) state_nx = RUN;
            RUN: begin
               // a pause request swallows a coincident tick and freezes the prescaler
               if (start_stop) begin
                  state_nx = PAUSE;
               end else if (presc == PMAX) begin
                  presc_nx = '0;
                  ind_nx   = ~indicator;
                  if (units == 4'd9) begin
                     units_nx = 4'd0;
                     tens_nx  = tens + 4'd1;
                  end else begin
                     units_nx = units + 4'd1;
                  end
                  if (tens == 4'd9 && units == 4'd8) begin
                     state_nx  = DONE;
                     freeze_nx = 1'b0;
                     ind_nx    = 1'b0;
                  end
               end else begin
                  presc_nx = presc + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      shown_t = freeze ? disp_t : tens;
      shown_u = freeze ? disp_u : units;
      digit1  = seg7(shown_t);
      digit0  = seg7(shown_u);
   end

endmodule

// File: tb/tb_stopwatch_ctrl_99sec.sv
// Directed scenarios plus randomized pulses checked against an integer-count stopwatch model.
module tb_stopwatch_ctrl_99sec;

   localparam int DIV = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic       lap = 1'b0;
   logic [0:6] digit1, digit0;
   logic       indicator, running, done;

   int errs = 0;
   int checks = 0;

   logic [0:6] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   // reference model: whole-second count as an integer, elapsed cycles within the second
   int m_mode = M_IDLE;
   int m_count = 0;
   int m_phase = 0;
   int m_disp = 0;
   bit m_freeze = 0;
   bit m_ind = 0;

   stopwatch_ctrl_99sec #(.DIV(DIV)) dut (
      .clkIn(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
      .digit1(digit1), .digit0(digit0), .indicator(indicator),
      .running(running), .done(done)
   );

   always #5 clk = ~clk;

   task automatic model_edge(input logic r, input logic ss, input logic cl, input logic lp);
      if (!r || cl) begin
         m_mode = M_IDLE; m_count = 0; m_phase = 0; m_freeze = 0; m_ind = 0;
         if (!r) m_disp = 0;
      end else begin
         if (lp && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
            if (!m_freeze) begin m_disp = m_count; m_freeze = 1; end
            else m_freeze = 0;
         end
         if (m_mode == M_IDLE) begin
            if (ss) m_mode = M_RUN;
         end else if (m_mode == M_PAUSE) begin
            if (ss) m_mode = M_RUN;
         end else if (m_mode == M_RUN) begin
            if (ss) m_mode = M_PAUSE;
            else if (m_phase == DIV - 1) begin
               m_phase = 0;
               m_count = m_count + 1;
               m_ind = !m_ind;
               if (m_count == 99) begin m_mode = M_DONE; m_freeze = 0; m_ind = 0; end
            end else m_phase = m_phase + 1;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic ss, input logic cl, input logic lp);
      rst = r; start_stop = ss; clear = cl; lap = lp;
      @(posedge clk);
      model_edge(r, ss, cl, lp);
      #1;
      rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (digit1 !== 7'b0000001) begin errs++; $display("FAIL reset_digit1 got %b want 0000001", digit1); end
      checks++; if (digit0 !== 7'b0000001) begin errs++; $display("FAIL reset_digit0 got %b want 0000001", digit0); end
      checks++; if (indicator !== 1'b0) begin errs++; $display("FAIL reset_indicator got %b want 0", indicator); end
      checks++; if (running !== 1'b0) begin errs++; $display("FAIL reset_running got %b want 0", running); end
      checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done); end
   endtask

   task automatic test_count;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (running !== 1'b1) begin errs++; $display("FAIL count_running got %b want 1", running); end
      idle(DIV - 1);
      checks++; if (digit0 !== segtab[0]) begin errs++; $display("FAIL count_before_first got %b want %b", digit0, segtab[0]); end
      idle(1);
      checks++; if (digit0 !== segtab[1]) begin errs++; $display("FAIL count_first_tick got %b want %b", digit0, segtab[1]); end
      idle(40 - DIV);
      checks++; if (digit1 !== 7'b1001111) begin errs++; $display("FAIL count10_digit1 got %b want 1001111", digit1); end
      checks++; if (digit0 !== 7'b0000001) begin errs++; $display("FAIL count10_digit0 got %b want 0000001", digit0); end
      checks++; if (indicator !== 1'b0) begin errs++; $display("FAIL count10_indicator got %b want 0", indicator); end
   endtask

   task automatic test_pause_resume;
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle(6);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle(20);
      checks++; if (running !== 1'b0) begin errs++; $display("FAIL pause_running got %b want 0", running); end
      checks++; if (digit0 !== segtab[1]) begin errs++; $display("FAIL pause_hold got %b want %b", digit0, segtab[1]); end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
      checks++; if (digit0 !== segtab[1]) begin errs++; $display("FAIL resume_plus1 got %b want %b", digit0, segtab[1]); end
      idle(1);
      checks++; if (digit0 !== segtab[2]) begin errs++; $display("FAIL resume_plus2 got %b want %b", digit0, segtab[2]); end
   endtask

   task automatic test_terminal;
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle(400);
      checks++; if (done !== 1'b1 || running !== 1'b0) begin errs++; $display("FAIL term_flags got done=%b running=%b want 1 0", done, running); end
      checks++; if ({digit1, digit0} !== {segtab[9], segtab[9]}) begin errs++; $display("FAIL term_99 got %b %b want %b %b", digit1, digit0, segtab[9], segtab[9]); end
      checks++; if (indicator !== 1'b0) begin errs++; $display("FAIL term_indicator got %b want 0", indicator); end
      for (int i = 0; i < 3; i++) begin cyc(1'b1, 1'b1, 1'b0, 1'b0); idle(5); end
      checks++; if ({digit1, digit0, done} !== {segtab[9], segtab[9], 1'b1}) begin errs++; $display("FAIL term_ignore_ss got %b %b done=%b", digit1, digit0, done); end
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      checks++; if ({digit1, digit0, done, running} !== {segtab[0], segtab[0], 2'b00}) begin errs++; $display("FAIL term_clear got %b %b done=%b run=%b", digit1, digit0, done, running); end
   endtask

   task automatic test_lap;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle(5 * DIV);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      idle(12);
      checks++; if ({digit1, digit0} !== {segtab[0], segtab[5]}) begin errs++; $display("FAIL lap_frozen got %b %b want %b %b", digit1, digit0, segtab[0], segtab[5]); end
      checks++; if (m_count != 8) begin errs++; $display("FAIL lap_model_count got %0d want 8", m_count); end
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      checks++; if ({digit1, digit0} !== {segtab[0], segtab[8]}) begin errs++; $display("FAIL lap_release got %b %b want %b %b", digit1, digit0, segtab[0], segtab[8]); end
   endtask

   task automatic test_collisions;
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle(2 * DIV);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      checks++; if ({digit1, digit0, running} !== {segtab[0], segtab[0], 1'b0}) begin errs++; $display("FAIL col_clear_ss got %b %b run=%b", digit1, digit0, running); end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle(DIV - 1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if ({digit0, running} !== {segtab[0], 1'b0}) begin errs++; $display("FAIL col_ss_tick got %b run=%b want %b 0", digit0, running, segtab[0]); end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
      checks++; if (digit0 !== segtab[1]) begin errs++; $display("FAIL col_resume_tick got %b want %b", digit0, segtab[1]); end
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle(37 * DIV);
      checks++; if ({digit1, digit0} !== {segtab[3], segtab[7]}) begin errs++; $display("FAIL col_at37 got %b %b want %b %b", digit1, digit0, segtab[3], segtab[7]); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if ({digit1, digit0, running, indicator} !== {segtab[0], segtab[0], 2'b00}) begin errs++; $display("FAIL col_rst37 got %b %b run=%b ind=%b", digit1, digit0, running, indicator); end
   endtask

   task automatic test_random;
      logic r, ss, cl, lp;
      logic [16:0] expv, act;
      int shown;
      for (int i = 0; i < 6000; i++) begin
         r  = ($urandom_range(0, 999) != 0);
         cl = ($urandom_range(0, 599) == 0);
         ss = ($urandom_range(0, 39) == 0);
         lp = ($urandom_range(0, 24) == 0);
         cyc(r, ss, cl, lp);
         shown = m_freeze ? m_disp : m_count;
         expv = {segtab[shown / 10], segtab[shown % 10], m_ind, m_mode == M_RUN, m_mode == M_DONE};
         act = {digit1, digit0, indicator, running, done};
         checks++;
         if (act !== expv) begin
            errs++;
            $display("FAIL random cycle %0d got %b want %b", i, act, expv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_pause_resume();
      test_terminal();
      test_lap();
      test_collisions();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
